uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_baud_gen.sv | 47 ++++
 rtl/uart_tx.sv | 128 ++++++++++++
 tb/tb_uart_tx.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter and receiver:
//   - default clock / bit-rate parameters
//   - clks_per_bit() helper (integer clocks per serial bit)
//   - state encodings (legacy-compatible constants plus a typed view)
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned BASE_CLK_DEFAULT = 50_000_000;
    localparam int unsigned BAUDRATE_DEFAULT = 115_200;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_START  = ST_START,
        S_DATA   = ST_DATA,
        S_PARITY = ST_PARITY,
        S_STOP   = ST_STOP
    } uart_state_e;

    function automatic int unsigned clks_per_bit(input int unsigned base_clk,
                                                 input int unsigned baudrate);
        return base_clk / baudrate;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_gen
// Bit-period counter. Counts 0..CLKS_PER_BIT-1 while enabled and wraps.
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-low reset
//   en    - count enable (held low: counter parked at 0)
//   clr   - synchronous clear (frame acceptance)
//   tick  - 1-cycle pulse in the last clock of each bit period
// ---------------------------------------------------------------------------
module uart_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned   CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = en && !clr && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr || !en) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// 8N1 UART transmitter (8E1 when UART_TX_PARITY_EN is defined: one even
// parity bit after the data bits).
// Ports:
//   clk         - system clock, rising edge
//   rst         - asynchronous active-low reset
//   tx_start    - send request, sampled only while idle
//   parallel_in - byte to send, LSB first, latched at acceptance
//   serial_out  - registered UART line, idle high
//   tx_busy     - high while a frame is in progress
//   tx_done     - 1-cycle pulse in the last clock of the stop bit
// ---------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned BASE_CLK = BASE_CLK_DEFAULT,
    parameter int unsigned BAUDRATE = BAUDRATE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] parallel_in,
    output logic       serial_out,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(BASE_CLK, BAUDRATE);

    uart_state_e state_q, state_d;
    logic [7:0]  data_q, data_d;
    logic [2:0]  idx_q, idx_d;
    logic        serial_out_q, serial_out_d;
    logic        accept;
    logic        bit_tick;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q != S_IDLE),
        .clr  (accept),
        .tick (bit_tick)
    );

    // The line value is derived from the next state so that serial_out,
    // although registered, changes on the same edge as the state.
    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        idx_d        = idx_q;
        serial_out_d = serial_out_q;
        accept       = 1'b0;
        case (state_q)
            S_IDLE: begin
                serial_out_d = 1'b1;
                if (tx_start) begin
                    accept       = 1'b1;
                    data_d       = parallel_in;
                    idx_d        = '0;
                    state_d      = S_START;
                    serial_out_d = 1'b0;
                end
            end
            S_START: begin
                if (bit_tick) begin
                    state_d      = S_DATA;
                    serial_out_d = data_q[0];
                end
            end
            S_DATA: begin
                if (bit_tick) begin
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d      = S_PARITY;
                        serial_out_d = ^data_q;
`else
                        state_d      = S_STOP;
                        serial_out_d = 1'b1;
`endif
                    end else begin
                        idx_d        = idx_q + 3'd1;
                        serial_out_d = data_q[idx_d];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_tick) begin
                    state_d      = S_STOP;
                    serial_out_d = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_tick) begin
                    state_d      = S_IDLE;
                    serial_out_d = 1'b1;
                end
            end
            default: begin
                state_d      = S_IDLE;
                serial_out_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            data_q       <= '0;
            idx_q        <= '0;
            serial_out_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            idx_q        <= idx_d;
            serial_out_q <= serial_out_d;
        end
    end

    assign serial_out = serial_out_q;
    assign tx_busy    = (state_q != S_IDLE);
    assign tx_done    = (state_q == S_STOP) && bit_tick;

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
// Directed self-checking bench for uart_tx at 50 MHz / 115200 (434 clocks
// per bit). Define UART_TX_PARITY_EN for the 11-bit-frame parity cases.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int CPB = 434;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] parallel_in = 8'h00;
    logic       serial_out;
    logic       tx_busy;
    logic       tx_done;

    int n_tests = 0;
    int n_fail  = 0;

    always #10 clk = ~clk;

    uart_tx #(
        .BASE_CLK(50_000_000),
        .BAUDRATE(115_200)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_start   (tx_start),
        .parallel_in(parallel_in),
        .serial_out (serial_out),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Request a frame; returns in the first cycle after the accepting edge.
    task automatic start_frame(input logic [7:0] b, input bit hold);
        tx_start    = 1'b1;
        parallel_in = b;
        step();
        if (!hold) tx_start = 1'b0;
    endtask

    // Watches one whole frame starting in the first cycle after acceptance
    // and ends in the first cycle after the stop bit.
    task automatic monitor_frame(input logic [7:0] b, input string tag,
                                 input int chg_at, input logic [7:0] chg_val);
        logic [FRAME_BITS-1:0] fb;
        int glitches, done_hits, done_at, busy_lows, bit_no;
        fb[0] = 1'b0;
        for (int k = 0; k < 8; k++) fb[k+1] = b[k];
`ifdef UART_TX_PARITY_EN
        fb[9] = ^b;
`endif
        fb[FRAME_BITS-1] = 1'b1;
        glitches = 0; done_hits = 0; done_at = 0; busy_lows = 0;
        for (int i = 0; i < FRAME_CYC; i++) begin
            bit_no = i / CPB;
            if (i == chg_at) parallel_in = chg_val;
            if (serial_out !== fb[bit_no]) glitches++;
            if (i % CPB == CPB / 2)
                check_eq($sformatf("%s_bit%0d", tag, bit_no), 32'(serial_out), 32'(fb[bit_no]));
            if (tx_done === 1'b1) begin
                done_hits++;
                done_at = i + 1;
            end
            if (tx_busy !== 1'b1) busy_lows++;
            step();
        end
        check_eq({tag, "_line_errs"}, 32'(glitches), 32'd0);
        check_eq({tag, "_done_count"}, 32'(done_hits), 32'd1);
        check_eq({tag, "_done_cycle"}, 32'(done_at), 32'(FRAME_CYC));
        check_eq({tag, "_busy_lows"}, 32'(busy_lows), 32'd0);
        check_eq({tag, "_gap_line"}, 32'(serial_out), 32'd1);
        check_eq({tag, "_gap_busy"}, 32'(tx_busy), 32'd0);
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int so_bad, busy_bad, done_bad;

        // Reset held low for 1000 ns with tx_start asserted.
        #1;
        rst         = 1'b0;
        tx_start    = 1'b1;
        parallel_in = 8'hA5;
        so_bad = 0; busy_bad = 0; done_bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (serial_out !== 1'b1) so_bad++;
            if (tx_busy !== 1'b0) busy_bad++;
            if (tx_done !== 1'b0) done_bad++;
        end
        check_eq("rst_line_errs", 32'(so_bad), 32'd0);
        check_eq("rst_busy_errs", 32'(busy_bad), 32'd0);
        check_eq("rst_done_errs", 32'(done_bad), 32'd0);
        @(posedge clk); #1;
        tx_start = 1'b0;
        rst      = 1'b1;
        so_bad = 0; busy_bad = 0; done_bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (serial_out !== 1'b1) so_bad++;
            if (tx_busy !== 1'b0) busy_bad++;
            if (tx_done !== 1'b0) done_bad++;
        end
        check_eq("idle_line_errs", 32'(so_bad), 32'd0);
        check_eq("idle_busy_errs", 32'(busy_bad), 32'd0);
        check_eq("idle_done_errs", 32'(done_bad), 32'd0);

        // Single 0xAA frame.
        start_frame(8'hAA, 1'b0);
        monitor_frame(8'hAA, "aa", -1, 8'h00);
        repeat (5) step();

        // tx_start held: back-to-back 0xFF frames, input changed mid-frame.
        start_frame(8'hFF, 1'b1);
        monitor_frame(8'hFF, "ff1", 2000, 8'hFF);
        step();
        monitor_frame(8'hFF, "ff2", 2000, 8'h00);
        tx_start = 1'b0;
        step();
        check_eq("ff_no_restart", 32'(tx_busy), 32'd0);
        repeat (5) step();

        // Reset during data bit 3 of 0x55, then a clean 0x3C frame.
        start_frame(8'h55, 1'b0);
        repeat (4 * CPB + 200) step();
        check_eq("r55_bit3_line", 32'(serial_out), 32'd0);
        check_eq("r55_bit3_busy", 32'(tx_busy), 32'd1);
        rst = 1'b0;
        #1;
        check_eq("r55_rst_line", 32'(serial_out), 32'd1);
        check_eq("r55_rst_busy", 32'(tx_busy), 32'd0);
        check_eq("r55_rst_done", 32'(tx_done), 32'd0);
        repeat (3) step();
        rst = 1'b1;
        repeat (2) step();
        start_frame(8'h3C, 1'b0);
        monitor_frame(8'h3C, "c3c", -1, 8'h00);

`ifdef UART_TX_PARITY_EN
        repeat (5) step();
        start_frame(8'h07, 1'b0);
        monitor_frame(8'h07, "p07", -1, 8'h00);
        repeat (5) step();
        start_frame(8'hAA, 1'b0);
        monitor_frame(8'hAA, "paa", -1, 8'h00);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
